// File: rtl/alu32_pkg.sv
// Shared encodings for the ALU32 multi-cycle logic unit: opcode and sequencer state.
package alu32_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   // Counter width that stays legal when the whole word fits in a single slice.
   function automatic int cnt_width(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/alu32_logic_seq_slice.sv
// One SLICE-bit chunk of the bitwise unit; the top feeds it the currently selected slice.
module logic_slice
   import alu32_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  op_t              op,
   output logic [SLICE-1:0] y
);

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu32_logic_seq.sv
// Multi-cycle AND/OR/XOR/NOR unit: latches a request, computes one slice per clock,
// then holds result/zero until the consumer accepts the response.
module alu32_logic_seq
   import alu32_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = cnt_width(NSLICE);
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("alu32_logic_seq: WIDTH must be a multiple of SLICE");
   end

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   op_t              op_q;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [SLICE-1:0] y;
   logic [WIDTH-1:0] result_nxt;

   // Slice selection by shifting keeps the datapath free of variable part-selects.
   assign a_sh = a_q >> (SLICE * int'(cnt));
   assign b_sh = b_q >> (SLICE * int'(cnt));

   logic_slice #(.SLICE(SLICE)) u_slice (
      .a  (a_sh[SLICE-1:0]),
      .b  (b_sh[SLICE-1:0]),
      .op (op_q),
      .y  (y)
   );

   // Merge the freshly computed slice into the running result; other bits pass through.
   always_comb begin
      result_nxt = result;
      for (int i = 0; i < NSLICE; i++) begin
         if (cnt == CW'(i)) begin
            result_nxt[i*SLICE +: SLICE] = y;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the operand and op registers are plain flops, not a memory, so they
         // take a defined reset value along with the control state.
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         result     <= '0;
         zero       <= 1'b0;
         cnt        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_AND;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  a_q       <= In1;
                  b_q       <= In2;
                  op_q      <= op_t'(op);
                  result    <= '0;
                  cnt       <= '0;
                  req_ready <= 1'b0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               result <= result_nxt;
               if (cnt == LAST) begin
                  zero       <= (result_nxt == '0);
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               // A waiting request is only taken from IDLE, one cycle after release.
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu32_logic_seq.sv
// Directed bench for alu32_logic_seq: default SLICE=8 unit plus a SLICE=4 instance.
module tb_alu32_logic_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [1:0]  op;
   logic [31:0] in1, in2;
   logic        resp_ready;
   logic        sel;

   logic        rv8, rv4;
   logic        req_ready8, req_ready4, resp_valid8, resp_valid4, zero8, zero4;
   logic [31:0] result8, result4;

   logic        req_ready, resp_valid, zero;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign rv8        = req_valid & ~sel;
   assign rv4        = req_valid & sel;
   assign req_ready  = sel ? req_ready4  : req_ready8;
   assign resp_valid = sel ? resp_valid4 : resp_valid8;
   assign result     = sel ? result4     : result8;
   assign zero       = sel ? zero4       : zero8;

   alu32_logic_seq #(.WIDTH(32), .SLICE(8)) dut8 (
      .clk(clk), .rst(rst), .req_valid(rv8), .req_ready(req_ready8), .op(op),
      .In1(in1), .In2(in2), .resp_valid(resp_valid8), .resp_ready(resp_ready),
      .result(result8), .zero(zero8)
   );

   alu32_logic_seq #(.WIDTH(32), .SLICE(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(req_ready4), .op(op),
      .In1(in1), .In2(in2), .resp_valid(resp_valid4), .resp_ready(resp_ready),
      .result(result4), .zero(zero4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request with resp_ready held high and check latency, data and release.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic ez,
                         input int lat, input bit scramble);
      int n;
      op = o; in1 = a; in2 = b; req_valid = 1'b1; resp_ready = 1'b1;
      check({tag, " req_ready before accept"}, 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 40) begin
         if (scramble) begin
            in1 = $urandom; in2 = $urandom; op = 2'($urandom_range(0, 3));
         end
         tick();
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'(lat));
      check({tag, " result"}, result, exp);
      check({tag, " zero"}, 32'(zero), 32'(ez));
      tick();
      check({tag, " resp_valid one cycle"}, 32'(resp_valid), 32'd0);
      check({tag, " req_ready back"}, 32'(req_ready), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b0; req_valid = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
      resp_ready = 1'b0; sel = 1'b0;
      do_reset();

      check("reset req_ready",  32'(req_ready),  32'd1);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      check("reset result",     result,          32'd0);
      check("reset zero",       32'(zero),       32'd0);

      for (int s = 0; s < 2; s++) begin
         int lat;
         sel = s[0];
         lat = (s == 0) ? 4 : 8;
         run_op("or",  2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, lat, 1'b0);
         run_op("xor", 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, lat, 1'b0);
         run_op("nor", 2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, lat, 1'b0);
         run_op("and", 2'b00, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0, lat, 1'b1);
      end
      sel = 1'b0;

      // Backpressure: response held while a new request waits.
      op = 2'b10; in1 = 32'hFF00_FF00; in2 = 32'h0FF0_0FF0;
      req_valid = 1'b1; resp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 40) begin
         tick();
         n++;
      end
      check("bp latency", 32'(n), 32'd4);
      op = 2'b01; in1 = 32'h0000_000A; in2 = 32'h0000_0005; req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp result held", result, 32'hF0F0_F0F0);
         check("bp zero held", 32'(zero), 32'd0);
         check("bp resp_valid held", 32'(resp_valid), 32'd1);
         check("bp req_ready low", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      tick();
      check("bp release resp_valid", 32'(resp_valid), 32'd0);
      check("bp release req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      check("bp pending accepted", 32'(req_ready), 32'd0);
      n = 0;
      while (!resp_valid && n < 40) begin
         tick();
         n++;
      end
      check("bp pending latency", 32'(n), 32'd4);
      check("bp pending result", result, 32'h0000_000F);
      tick();

      // Reset on the second BUSY edge discards the partial result.
      op = 2'b01; in1 = 32'hFFFF_FFFF; in2 = 32'h0; req_valid = 1'b1; resp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      check("mid-busy partial", result, 32'h0000_00FF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid-busy rst resp_valid", 32'(resp_valid), 32'd0);
      check("mid-busy rst result", result, 32'd0);
      check("mid-busy rst req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      check("mid-busy no response", 32'(resp_valid), 32'd0);
      run_op("post-rst or", 2'b01, 32'h1, 32'h2, 32'h3, 1'b0, 4, 1'b0);

      // Reset in DONE with resp_ready low, then reset and request on the same edge.
      op = 2'b11; in1 = 32'h0; in2 = 32'h0; req_valid = 1'b1; resp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("done before rst", 32'(resp_valid), 32'd1);
      rst = 1'b1; req_valid = 1'b1;
      tick();
      rst = 1'b0; req_valid = 1'b0;
      check("rst wins req_ready", 32'(req_ready), 32'd1);
      check("rst wins resp_valid", 32'(resp_valid), 32'd0);
      check("rst wins result", result, 32'd0);
      tick();
      check("rst wins still idle", 32'(req_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
